// File: rtl/seg_scan_mux_4_to_1_pkg.sv
// Shared types and constants for the 4-to-1 segment scanner.
// The BLANK state is used only when the design is built with SCAN_BLANK_EN.
package seg_scan_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHOW  = 2'd1,
    BLANK = 2'd2
  } state_t;

  localparam int         NUM_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK  = 8'h00;
  localparam logic [3:0] AN_ALL_OFF = 4'b1111;

  // Counter width that stays legal for a terminal count of 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [3:0] an_select(input logic [1:0] k);
    return ~(4'b0001 << k);
  endfunction

endpackage

// File: rtl/seg_scan_mux_4_to_1_if.sv
// Pattern inputs and display-side outputs of the segment scanner.
// The slave modport is the scanner, the master modport is whatever drives it.
interface seg_scan_mux_4_to_1_if;
  logic       i_en;
  logic [7:0] i_a;
  logic [7:0] i_b;
  logic [7:0] i_c;
  logic [7:0] i_d;
  logic [7:0] o_seg;
  logic [3:0] o_an_n;
  logic [1:0] o_sel;
  logic       o_frame;

  modport master (
    output i_en, i_a, i_b, i_c, i_d,
    input  o_seg, o_an_n, o_sel, o_frame
  );

  modport slave (
    input  i_en, i_a, i_b, i_c, i_d,
    output o_seg, o_an_n, o_sel, o_frame
  );
endinterface

// File: rtl/seg_scan_mux_4_to_1_tick_gen.sv
// Dwell counter: counts from 0 while not cleared, o_tick marks the last
// cycle of an N-cycle interval.
module scan_tick_gen
  import seg_scan_pkg::*;
#(
  parameter int N = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tick
);

  localparam int W = cnt_width(N);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)      cnt <= '0;
    else if (i_clr) cnt <= '0;
    else            cnt <= cnt + W'(1);
  end

  assign o_tick = (cnt == W'(N - 1));

endmodule

// File: rtl/seg_scan_mux_4_to_1.sv
// Time-division 4-to-1 display scanner with per-frame input snapshot.
// Define SCAN_BLANK_EN to insert BLANK_CYCLES of all-off dead time between digits.
module seg_scan_mux_4_to_1
  import seg_scan_pkg::*;
#(
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  seg_scan_mux_4_to_1_if.slave  bus
);

  state_t     state;
  logic       en_q;
  logic [1:0] k;
  logic [1:0] k_nxt;
  logic [7:0] snap [NUM_DIGITS];

  logic show_tick;
  logic show_clr;
  logic advance;

  assign k_nxt    = k + 2'd1;
  // Counters restart on every state entry, so no dwell carries over.
  assign show_clr = (state != SHOW) || show_tick;

  scan_tick_gen #(.N(PRESCALE)) u_show_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (show_clr),
    .o_tick (show_tick)
  );

`ifdef SCAN_BLANK_EN
  logic blank_tick;
  logic blank_clr;
  logic to_blank;

  assign blank_clr = (state != BLANK) || blank_tick;
  assign to_blank  = (state == SHOW) && show_tick;
  assign advance   = (state == BLANK) && blank_tick;

  scan_tick_gen #(.N(BLANK_CYCLES)) u_blank_tick (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (blank_clr),
    .o_tick (blank_tick)
  );
`else
  assign advance = (state == SHOW) && show_tick;
`endif

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state       <= IDLE;
      en_q        <= 1'b0;
      k           <= 2'd0;
      // NOTE: the snapshot is a handful of flops, not a RAM, so it is reset
      // to a known value like the rest of the state.
      for (int i = 0; i < NUM_DIGITS; i++) snap[i] <= '0;
      bus.o_seg   <= SEG_BLANK;
      bus.o_an_n  <= AN_ALL_OFF;
      bus.o_sel   <= 2'd0;
      bus.o_frame <= 1'b0;
    end else begin
      en_q        <= bus.i_en;
      bus.o_frame <= 1'b0;
      if (!en_q) begin
        state      <= IDLE;
        k          <= 2'd0;
        bus.o_seg  <= SEG_BLANK;
        bus.o_an_n <= AN_ALL_OFF;
        bus.o_sel  <= 2'd0;
      end else if (state == IDLE || (advance && k_nxt == 2'd0)) begin
        // Frame start: capture all four patterns and show digit 0 at once.
        state       <= SHOW;
        k           <= 2'd0;
        snap[0]     <= bus.i_a;
        snap[1]     <= bus.i_b;
        snap[2]     <= bus.i_c;
        snap[3]     <= bus.i_d;
        bus.o_seg   <= bus.i_a;
        bus.o_an_n  <= an_select(2'd0);
        bus.o_sel   <= 2'd0;
        bus.o_frame <= 1'b1;
      end else if (advance) begin
        state      <= SHOW;
        k          <= k_nxt;
        bus.o_seg  <= snap[k_nxt];
        bus.o_an_n <= an_select(k_nxt);
        bus.o_sel  <= k_nxt;
`ifdef SCAN_BLANK_EN
      end else if (to_blank) begin
        state      <= BLANK;
        bus.o_seg  <= SEG_BLANK;
        bus.o_an_n <= AN_ALL_OFF;
`endif
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_mux_4_to_1.sv
// Directed check of seg_scan_mux_4_to_1 with PRESCALE=4, BLANK_CYCLES=2,
// for either build of SCAN_BLANK_EN.
module tb_seg_scan_mux_4_to_1;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [3:0] an_tab [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
  logic [3:0] prev_an;

  always #5 clk = ~clk;

  seg_scan_mux_4_to_1_if bus ();

  seg_scan_mux_4_to_1 #(.PRESCALE(4), .BLANK_CYCLES(2)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Packed as {an_n, seg, sel, frame}.
  task automatic check_out(input string tag, input logic [3:0] an, input logic [7:0] seg,
                           input logic [1:0] sel, input logic frame);
    check(tag, {17'b0, bus.o_an_n, bus.o_seg, bus.o_sel, bus.o_frame},
               {17'b0, an, seg, sel, frame});
  endtask

  task automatic check_idle(input string tag);
    check_out(tag, 4'b1111, 8'h00, 2'd0, 1'b0);
  endtask

  task automatic show_digit(input int k, input logic [7:0] seg, input bit first);
    for (int i = 0; i < 4; i++) begin
      check_out($sformatf("digit%0d_c%0d", k, i), an_tab[k], seg, 2'(k), first && (i == 0));
      @(negedge clk);
    end
  endtask

  task automatic blank_gap(input int k);
`ifdef SCAN_BLANK_EN
    for (int i = 0; i < 2; i++) begin
      check_out($sformatf("blank%0d_c%0d", k, i), 4'b1111, 8'h00, 2'(k), 1'b0);
      @(negedge clk);
    end
`endif
  endtask

  initial begin
    rst = 1'b1;
    bus.i_en = 1'b0;
    bus.i_a = 8'h00; bus.i_b = 8'h00; bus.i_c = 8'h00; bus.i_d = 8'h00;
    #2 check_idle("reset_values");
    @(negedge clk) rst = 1'b0;

    bus.i_a = 8'h3F; bus.i_b = 8'h06; bus.i_c = 8'h5B; bus.i_d = 8'h4F;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) check_idle("idle_en_low");
    end

    // Start-up: one cycle to sample i_en, outputs switch on the next edge.
    bus.i_en = 1'b1;
    @(negedge clk) check_idle("startup_latency");
    @(negedge clk);

    show_digit(0, 8'h3F, 1); blank_gap(0);
    show_digit(1, 8'h06, 0); blank_gap(1);
    show_digit(2, 8'h5B, 0); blank_gap(2);
    show_digit(3, 8'h4F, 0); blank_gap(3);

    // Second frame: inputs change mid-frame, must not tear this frame.
    show_digit(0, 8'h3F, 1); blank_gap(0);
    show_digit(1, 8'h06, 0); blank_gap(1);
    bus.i_a = 8'h66; bus.i_d = 8'h77;
    show_digit(2, 8'h5B, 0); blank_gap(2);
    show_digit(3, 8'h4F, 0); blank_gap(3);

    // Third frame picks up the new snapshot.
    show_digit(0, 8'h66, 1); blank_gap(0);
    show_digit(1, 8'h06, 0); blank_gap(1);

    // Abort: i_en low takes effect two edges later regardless of state.
`ifdef SCAN_BLANK_EN
    show_digit(2, 8'h5B, 0);
    bus.i_en = 1'b0;
    check_out("abort_c0", 4'b1111, 8'h00, 2'd2, 1'b0);
    @(negedge clk) check_out("abort_c1", 4'b1111, 8'h00, 2'd2, 1'b0);
`else
    bus.i_en = 1'b0;
    check_out("abort_c0", 4'b1011, 8'h5B, 2'd2, 1'b0);
    @(negedge clk) check_out("abort_c1", 4'b1011, 8'h5B, 2'd2, 1'b0);
`endif
    @(negedge clk) check_idle("abort_idle");
    for (int i = 0; i < 2; i++) begin
      @(negedge clk) check_idle("abort_hold");
    end

    // Restart from digit 0 with a fresh snapshot and a frame pulse.
    bus.i_a = 8'h11;
    bus.i_en = 1'b1;
    @(negedge clk) check_idle("restart_latency");
    @(negedge clk);
    show_digit(0, 8'h11, 1); blank_gap(0);
    show_digit(1, 8'h06, 0); blank_gap(1);

    // Asynchronous reset in the middle of digit 2, between clock edges.
    #2 rst = 1'b1;
    #1 check_idle("async_reset");
    bus.i_en = 1'b0;
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk) check_idle("post_reset_hold");
    end

    // Soak: random enable and patterns, digit enables must never overlap.
    prev_an = 4'b1111;
    bus.i_en = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      @(negedge clk);
      check("onehot_an", 32'($countones(~bus.o_an_n) <= 1), 32'd1);
`ifdef SCAN_BLANK_EN
      if (bus.o_an_n != 4'b1111 && prev_an != 4'b1111)
        check("no_ghost", 32'(bus.o_an_n), 32'(prev_an));
`endif
      prev_an  = bus.o_an_n;
      bus.i_en = ($urandom_range(0, 31) != 0);
      bus.i_a  = 8'($urandom);
      bus.i_b  = 8'($urandom);
      bus.i_c  = 8'($urandom);
      bus.i_d  = 8'($urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
